// File: rtl/sfifo_stream_out.sv
// Drains sfifo onto a valid/ready stream through a credit-limited skid buffer; optional word_cnt via SFIFO_STREAM_OUT_CNT_EN.
// Latency: r_en at edge N -> word captured and m_valid high from edge N+RD_LAT; m_data is always driven from skid storage.
// Backpressure: r_en is only issued while in-flight reads plus held words leave room in the skid, so nothing is lost under m_ready=0.
module sfifo_stream_out #(
    parameter int DW         = 8,
    parameter int RD_LAT     = 1,
    parameter int SKID_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_dout,
    input  logic          fifo_udfl,
    output logic          fifo_r_en,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    input  logic          m_ready,
    input  logic          flush,
    output logic          err
`ifdef SFIFO_STREAM_OUT_CNT_EN
    ,
    output logic [15:0]   word_cnt
`endif
);

    localparam int CW  = $clog2(SKID_DEPTH + 1);
    localparam int CRW = $clog2(2 * SKID_DEPTH + 1);
    localparam int PW  = $clog2(SKID_DEPTH);
    localparam logic [CW-1:0]  FULL  = CW'(SKID_DEPTH);
    localparam logic [PW-1:0]  LAST  = PW'(SKID_DEPTH - 1);
    localparam logic [CRW-1:0] LIMIT = CRW'(SKID_DEPTH);

    logic [RD_LAT-1:0] r_pipe;
    logic [RD_LAT-1:0] w_pipe_nxt;
    logic [DW-1:0]     r_mem [SKID_DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic              r_err;
    logic [CRW-1:0]    w_inflight;
    logic [CRW-1:0]    w_credit;
    logic              w_cap;
    logic              w_pop;
    logic              w_full;
    logic              w_wr;
    logic              w_drop;

    always_comb begin
        w_pipe_nxt    = '0;
        w_pipe_nxt[0] = fifo_r_en;
        for (int i = 1; i < RD_LAT; i++) begin
            w_pipe_nxt[i] = r_pipe[i-1];
        end
    end

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + CRW'(r_pipe[i]);
        end
    end

    assign w_pop    = m_valid & m_ready;
    assign w_full   = (r_count == FULL);
    assign w_cap    = r_pipe[RD_LAT-1] & ~flush;
    assign w_wr     = w_cap & (~w_full | w_pop);
    assign w_drop   = w_cap & w_full & ~w_pop;
    // Subtracting this cycle's pop lets a full skid keep streaming at one word per cycle.
    assign w_credit = w_inflight + CRW'(r_count) - CRW'(w_pop);

    assign fifo_r_en = rst & ~fifo_empty & ~flush & (w_credit < LIMIT);
    assign m_valid   = (r_count != '0);
    assign m_data    = r_mem[r_rptr];
    assign err       = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pipe <= '0;
        end else if (flush) begin
            r_pipe <= '0;
        end else begin
            r_pipe <= w_pipe_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr) begin
            r_mem[r_wptr] <= fifo_dout;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= (r_wptr == LAST) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == LAST) ? '0 : r_rptr + 1'b1;
            end
            if (w_wr && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_wr && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (flush) begin
            r_err <= 1'b0;
        end else if (fifo_udfl || w_drop) begin
            r_err <= 1'b1;
        end
    end

`ifdef SFIFO_STREAM_OUT_CNT_EN
    logic [15:0] r_word_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word_cnt <= '0;
        end else if (flush) begin
            r_word_cnt <= '0;
        end else if (w_pop) begin
            r_word_cnt <= r_word_cnt + 16'd1;
        end
    end

    assign word_cnt = r_word_cnt;
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst) begin
            assert (w_inflight + CRW'(r_count) <= LIMIT)
                else $error("sfifo_stream_out: in-flight plus held words exceed skid depth");
        end
    end
`endif

endmodule

// File: doc/sfifo_stream_out.md
Name: sfifo_stream_out

Overview:
Read-side drain stage placed directly downstream of sfifo. It issues r_en to the FIFO whenever the FIFO holds data and local credit is available. It absorbs the FIFO's fixed read latency in a small skid buffer. It presents the words on a valid/ready stream with registered data, in order, with no loss or duplication under any backpressure pattern.

Parameters:
DW, 8, data width; must match sfifo din/dout width.
RD_LAT, 1, cycles from r_en sampled high at a posedge until dout is valid for capture; range 1..4.
SKID_DEPTH, 2, skid buffer entries; must be >= RD_LAT+1 for full throughput; range 2..8.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
fifo_empty  in  1  sfifo empty flag.
fifo_dout  in  DW  sfifo read data.
fifo_udfl  in  1  sfifo underflow pulse.
fifo_r_en  out  1  read enable to sfifo.
m_valid  out  1  output word valid.
m_data  out  DW  output word.
m_ready  in  1  downstream accepts word.
flush  in  1  synchronous flush request.
err  out  1  sticky error flag.

Behaviour:
- Reset (rst=0, async): fifo_r_en=0, m_valid=0, m_data=0, err=0. Skid count, pointers and the in-flight pipe all clear.
- In-flight tracking: an RD_LAT-deep shift register of valid bits. Bit 0 loads fifo_r_en; the last stage, when high, marks fifo_dout as valid this cycle.
- inflight = popcount(pipe). count = skid occupancy, 0..SKID_DEPTH. pop = m_valid & m_ready.
- fifo_r_en (combinational) = !fifo_empty & !flush & (inflight + count - pop) < SKID_DEPTH. The m_ready to fifo_r_en combinational path is permitted.
- Credit arithmetic uses a width of clog2(2*SKID_DEPTH+1) bits. The sum must never exceed SKID_DEPTH; violating this is a design error, so assert it in simulation.
- Capture: at a posedge where the pipe's last stage is high and flush=0, write fifo_dout into skid[wptr]. wptr wraps modulo SKID_DEPTH.
- Output: m_valid = (count != 0). m_data = skid[rptr], read from storage only, with no combinational path from fifo_dout.
- On pop, rptr advances and wraps modulo SKID_DEPTH. On a simultaneous capture and pop, count is unchanged.
- Latency: r_en at edge N, data captured at edge N+RD_LAT, m_valid high from edge N+RD_LAT.
- Throughput: with m_ready held at 1, fifo_r_en stays high one word per cycle while FIFO is non-empty.
- Stability: while m_valid=1 and m_ready=0, m_data and m_valid hold.
- fifo_empty=1: fifo_r_en=0, with no exceptions.
- Flush (sampled at posedge): clears count, rptr, wptr and every pipe bit; err clears to 0. Data returning from reads issued before the flush is discarded. fifo_r_en=0 during the flush cycle. m_valid=0 from the following cycle.
- err: set when fifo_udfl is sampled high, or when a capture occurs with count==SKID_DEPTH and no pop (the write is dropped). Cleared only by reset or flush.

Optional Feature:
Macro SFIFO_STREAM_OUT_CNT_EN.
- Defined: adds output port word_cnt, 16 bits. It increments on each pop and wraps 0xFFFF to 0x0000. Reset and flush set it to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. Reset (defaults: DW=8, RD_LAT=1, SKID_DEPTH=2): rst low for 4 clocks, FIFO non-empty -> fifo_r_en=0, m_valid=0, m_data=0x00, err=0 throughout.
2. Streaming: FIFO preloaded with 0x11,0x12,0x13,0x14, m_ready=1 -> fifo_r_en high 4 consecutive cycles. m_data shows 0x11..0x14 on 4 consecutive cycles starting 1 cycle after the first r_en. There is no r_en once empty rises.
3. Backpressure: 10 words loaded, m_ready=0 -> exactly 2 r_en pulses, then r_en low, with m_data held at the first word. Release m_ready -> all 10 words delivered in order, no duplicates.
4. Single word: FIFO holds 0xA5 only -> exactly one r_en, one m_valid beat carrying 0xA5, and r_en never high while fifo_empty=1.
5. Flush mid-flight: flush asserted the cycle after an r_en -> the returning word is dropped, m_valid=0 next cycle, and the subsequent stream resumes with the next FIFO word.
6. Error: pulse fifo_udfl for 1 cycle -> err=1 and stays high; assert flush -> err=0. With SFIFO_STREAM_OUT_CNT_EN defined, after 5 pops -> word_cnt=5, and flush -> 0.
